// File: rtl/mac_psum_acc.sv
// mac_psum_acc: accumulates signed partial sums from a 16-input MAC into
// groups closed by in_last or by the chunk limit. Each result is held
// until the consumer takes it, with an optional ReLU clamp.
module mac_psum_acc #(
  parameter int bw        = 8,
  parameter int bw_psum   = 2*bw+6,
  parameter int max_chunk = 16,
  parameter int bw_acc    = bw_psum+4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [bw_psum-1:0] in_psum,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  input  logic               relu_en,
  output logic [bw_acc-1:0]  out_data,
  output logic [4:0]         out_cnt,
  output logic               out_forced,
  output logic               out_valid,
  input  logic               out_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no group open
    ACC  = 2'd1,  // group open, accumulating
    HOLD = 2'd2   // result presented, waiting for consumer
  } state_t;

  state_t              state, state_nx;
  logic [bw_acc-1:0]   acc;
  logic [4:0]          cnt;
  logic [bw_acc-1:0]   psum_ext;
  logic [bw_acc-1:0]   acc_sum;
  logic [4:0]          cnt_sum;
  logic                accept;
  logic                close;

  // The input side stalls only while a result is waiting.
  assign in_ready = (state != HOLD);
  assign accept   = in_valid && in_ready;

  // The accumulator is wide enough that max_chunk psums cannot wrap.
  assign psum_ext = {{(bw_acc-bw_psum){in_psum[bw_psum-1]}}, in_psum};

  // The first psum of a group replaces the accumulator instead of adding to it.
  assign acc_sum = (state == IDLE) ? psum_ext : acc + psum_ext;
  assign cnt_sum = (state == IDLE) ? 5'd1 : cnt + 5'd1;

  // A group closes on an explicit last marker or when the chunk limit is reached.
  assign close = accept && (in_last || (cnt_sum == 5'(max_chunk)));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first, so no path through the case leaves state_nx
    // unassigned and no latch is inferred.
    state_nx = state;
    unique case (state)
      IDLE, ACC: if (accept) state_nx = close ? HOLD : ACC;
      HOLD:      if (out_valid && out_ready) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Running sum and count of the open group.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      acc <= acc_sum;
      cnt <= cnt_sum;
    end
  end

  // Result registers: loaded on close, held stable until the handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data   <= '0;
      out_cnt    <= '0;
      out_forced <= 1'b0;
      out_valid  <= 1'b0;
    end else if (close) begin
      out_data   <= (relu_en && acc_sum[bw_acc-1]) ? '0 : acc_sum;
      out_cnt    <= cnt_sum;
      out_forced <= !in_last;
      out_valid  <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_psum_acc.sv
// tb_mac_psum_acc: directed scenarios plus a randomized stream checked
// against a plain-arithmetic reference model of the group accumulator.
module tb_mac_psum_acc;

  localparam int BW_PSUM = 22;
  localparam int BW_ACC  = 26;
  localparam int MAXC    = 16;

  logic               clk;
  logic               reset_n;
  logic [BW_PSUM-1:0] in_psum;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic               relu_en;
  logic [BW_ACC-1:0]  out_data;
  logic [4:0]         out_cnt;
  logic               out_forced;
  logic               out_valid;
  logic               out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  mac_psum_acc #(
    .bw(8), .bw_psum(BW_PSUM), .max_chunk(MAXC), .bw_acc(BW_ACC)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_psum(in_psum), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .relu_en(relu_en),
    .out_data(out_data), .out_cnt(out_cnt), .out_forced(out_forced),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int p, input logic l);
    in_valid = v;
    in_psum  = BW_PSUM'(p);
    in_last  = l;
  endtask

  // Hand the pending result to the consumer and return to idle inputs.
  task automatic consume();
    drive(1'b0, 0, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; drive(1'b0, 0, 1'b0); relu_en = 1'b0; out_ready = 1'b0;
    #12;
    n_checks++;
    if ({out_valid, out_forced, out_cnt, out_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b f=%0b c=%0d d=%0h, want all 0",
               out_valid, out_forced, out_cnt, out_data);
    end
    @(negedge clk); reset_n = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %0b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    drive(1'b1, 100, 1'b0); tick();
    drive(1'b1, -30, 1'b0); tick();
    drive(1'b1, 7, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_early_valid: got %0b want 0", out_valid);
    end
    tick();
    drive(1'b0, 0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== BW_ACC'(77) || out_cnt !== 5'd3
        || out_forced !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: got v=%0b d=%0d c=%0d f=%0b rdy=%0b, want 1 77 3 0 0",
               out_valid, $signed(out_data), out_cnt, out_forced, in_ready);
    end
    consume();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_release: got v=%0b rdy=%0b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_forced();
    int ready_after_15;
    for (int i = 0; i < MAXC; i++) begin
      drive(1'b1, -(1 << 21), 1'b0);
      tick();
      if (i == MAXC-2) ready_after_15 = int'(in_ready);
    end
    drive(1'b0, 0, 1'b0);
    n_checks++;
    if (ready_after_15 != 1) begin
      n_fail++; $display("FAIL forced_ready_15: got %0d want 1", ready_after_15);
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== BW_ACC'(-(1 << 25)) || out_cnt !== 5'd16
        || out_forced !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL forced_result: got v=%0b d=%0d c=%0d f=%0b rdy=%0b, want 1 -33554432 16 1 0",
               out_valid, $signed(out_data), out_cnt, out_forced, in_ready);
    end
    consume();
  endtask

  task automatic test_relu();
    for (int r = 1; r >= 0; r--) begin
      relu_en = 1'b0;
      drive(1'b1, -5, 1'b0); tick();
      relu_en = r[0];
      drive(1'b1, 2, 1'b1); tick();
      relu_en = 1'b0;
      drive(1'b0, 0, 1'b0);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== BW_ACC'(r ? 0 : -3) || out_cnt !== 5'd2) begin
        n_fail++;
        $display("FAIL relu_%0d: got v=%0b d=%0d c=%0d, want 1 %0d 2",
                 r, out_valid, $signed(out_data), out_cnt, r ? 0 : -3);
      end
      consume();
    end
  endtask

  task automatic test_gap();
    drive(1'b1, 10, 1'b0); tick();
    drive(1'b0, 999, 1'b1); tick();   // last without valid: ignored
    drive(1'b0, 0, 1'b0); tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL gap_open: got v=%0b rdy=%0b want 0 1", out_valid, in_ready);
    end
    drive(1'b1, 5, 1'b1); tick();
    drive(1'b0, 0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== BW_ACC'(15) || out_cnt !== 5'd2
        || out_forced !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_result: got v=%0b d=%0d c=%0d f=%0b, want 1 15 2 0",
               out_valid, $signed(out_data), out_cnt, out_forced);
    end
    consume();
  endtask

  task automatic test_backpressure();
    drive(1'b1, 50, 1'b0); tick();
    drive(1'b1, -8, 1'b1); tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1000 + i, i[0]);   // ignored while a result is held
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== BW_ACC'(42) || out_cnt !== 5'd2
          || out_forced !== 1'b0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_cycle_%0d: got v=%0b d=%0d c=%0d f=%0b rdy=%0b, want 1 42 2 0 0",
                 i, out_valid, $signed(out_data), out_cnt, out_forced, in_ready);
      end
      tick();
    end
    consume();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL hold_release: got v=%0b rdy=%0b want 0 1", out_valid, in_ready);
    end
    drive(1'b1, 4, 1'b1); tick();
    drive(1'b0, 0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== BW_ACC'(4) || out_cnt !== 5'd1) begin
      n_fail++;
      $display("FAIL hold_after: got v=%0b d=%0d c=%0d, want 1 4 1",
               out_valid, $signed(out_data), out_cnt);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 11, 1'b0); tick();
    drive(1'b1, 22, 1'b0); tick();
    drive(1'b0, 0, 1'b0);
    #2 reset_n = 1'b0;
    #2;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midreset_async: got v=%0b rdy=%0b want 0 1", out_valid, in_ready);
    end
    @(negedge clk); reset_n = 1'b1;
    tick(); tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_novalid: got %0b want 0", out_valid);
    end
    drive(1'b1, 9, 1'b1); tick();
    drive(1'b0, 0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== BW_ACC'(9) || out_cnt !== 5'd1
        || out_forced !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_single: got v=%0b d=%0d c=%0d f=%0b, want 1 9 1 0",
               out_valid, $signed(out_data), out_cnt, out_forced);
    end
    consume();
  endtask

  // Randomized stream against a model: a group is a list of psums whose
  // exact sum and length become the result; the result blocks input until taken.
  task automatic test_random();
    longint m_sum = 0;
    int     m_cnt = 0;
    bit     m_hold = 1'b0;
    longint m_data = 0;
    int     m_ocnt = 0;
    bit     m_forced = 1'b0;
    int     groups_closed = 0;
    int     results_taken = 0;
    logic signed [BW_PSUM-1:0] r;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r = BW_PSUM'($urandom);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_psum   = r;
      in_last   = ($urandom_range(0, 5) == 0);
      relu_en   = $urandom_range(0, 1) == 1;
      out_ready = ($urandom_range(0, 9) < 6);
      n_checks++;
      if (in_ready !== !m_hold) begin
        n_fail++; $display("FAIL rand_ready cyc %0d: got %0b want %0b", cyc, in_ready, !m_hold);
      end
      if (m_hold) begin
        if (out_ready) begin
          m_hold = 1'b0;
          results_taken++;
        end
      end else if (in_valid) begin
        m_sum += longint'(r);
        m_cnt++;
        if (in_last || m_cnt == MAXC) begin
          m_data   = (relu_en && m_sum < 0) ? 0 : m_sum;
          m_ocnt   = m_cnt;
          m_forced = !in_last;
          m_hold   = 1'b1;
          m_sum    = 0;
          m_cnt    = 0;
          groups_closed++;
        end
      end
      tick();
      n_checks++;
      if (out_valid !== m_hold || (m_hold && (out_data !== BW_ACC'(m_data)
          || out_cnt !== 5'(m_ocnt) || out_forced !== m_forced))) begin
        n_fail++;
        $display("FAIL rand_out cyc %0d: got v=%0b d=%0d c=%0d f=%0b, want v=%0b d=%0d c=%0d f=%0b",
                 cyc, out_valid, $signed(out_data), out_cnt, out_forced,
                 m_hold, m_data, m_ocnt, m_forced);
      end
    end
    // Drain: close any open group and take the final result.
    out_ready = 1'b0;
    if (!m_hold) begin
      if (m_cnt != 0) begin
        drive(1'b1, 0, 1'b1); tick();
        groups_closed++;
      end
    end
    drive(1'b0, 0, 1'b0);
    if (out_valid) begin
      consume();
      results_taken++;
    end
    n_checks++;
    if (groups_closed != results_taken || groups_closed < 50) begin
      n_fail++;
      $display("FAIL rand_group_count: closed %0d taken %0d (need equal, >= 50)",
               groups_closed, results_taken);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_forced();
    test_relu();
    test_gap();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_psum_acc.md
MAC_PSUM_ACC -- requirements
Module: mac_psum_acc

Interface
REQ-001 SHALL have parameter bw, default 8, meaning operand width of the upstream 16-input MAC.
REQ-002 SHALL have parameter bw_psum, default 2*bw+6 (22), meaning width of the signed partial sum received from the MAC.
REQ-003 SHALL have parameter max_chunk, default 16, meaning the maximum number of psums per group; it SHALL be a power of two, 2..16.
REQ-004 SHALL have parameter bw_acc, default bw_psum+4 (26), meaning accumulator and output width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port in_psum, input, bw_psum bits: signed two's-complement partial sum from the MAC.
REQ-008 SHALL have port in_valid, input, 1 bit: in_psum is valid this cycle.
REQ-009 SHALL have port in_last, input, 1 bit: qualified by in_valid; marks the final psum of a group.
REQ-010 SHALL have port in_ready, output, 1 bit: the block accepts a psum this cycle.
REQ-011 SHALL have port relu_en, input, 1 bit: sampled at group close; clamps negative results to 0.
REQ-012 SHALL have port out_data, output, bw_acc bits: signed accumulated group result.
REQ-013 SHALL have port out_cnt, output, 5 bits: number of psums in the reported group (1..max_chunk).
REQ-014 SHALL have port out_forced, output, 1 bit: the group was closed by the chunk limit, not by in_last.
REQ-015 SHALL have port out_valid, output, 1 bit: out_data/out_cnt/out_forced are valid.
REQ-016 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the result.

Function
REQ-017 SHALL implement states IDLE (no group open), ACC (group open) and HOLD (result presented).
REQ-018 SHALL define accept as in_valid && in_ready; in_ready SHALL be 1 in IDLE and ACC and 0 in HOLD.
REQ-019 On accept in IDLE, SHALL load acc with sign-extended in_psum, set cnt=1 and go to ACC, unless close (REQ-021) applies.
REQ-020 On accept in ACC, SHALL set acc = acc + sign-extended in_psum and cnt = cnt+1; the sum is exact, with no wrap for up to max_chunk psums.
REQ-021 A group SHALL close on the accepting edge when in_last=1 or the post-increment cnt equals max_chunk; the block then goes to HOLD.
REQ-022 On close, SHALL register out_data = (relu_en && final acc<0) ? 0 : final acc, out_cnt = final cnt, out_forced = (in_last==0), and set out_valid=1 on the next cycle.
REQ-023 In HOLD, outputs SHALL remain stable until out_valid && out_ready; on that edge the block SHALL go to IDLE with out_valid=0 and in_ready=1 in the following cycle.
REQ-024 Latency SHALL be 1 cycle from the closing accept edge to out_valid high; throughput SHALL be 1 psum per cycle within a group, with one bubble cycle per group (HOLD state).
REQ-025 A single-psum group (in_last on the first accept) SHALL produce out_cnt=1 and out_data equal to the sign-extended psum.
REQ-026 In_valid=0 in ACC SHALL hold acc and cnt unchanged; idle gaps inside a group are legal.
REQ-027 in_last without in_valid SHALL be ignored; in_valid/in_psum/in_last SHALL be ignored while in HOLD.
REQ-028 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-029 On reset_n=0, SHALL asynchronously set state=IDLE, acc=0, cnt=0, out_data=0, out_cnt=0, out_forced=0 and out_valid=0; in_ready SHALL read 1 after release.
REQ-030 Reset asserted mid-group or in HOLD SHALL discard the open group or unconsumed result; no partial result SHALL ever be emitted.
REQ-031 The first accept after reset_n deasserts SHALL be treated as the first psum of a new group.

Verification
REQ-032 Psums 100, -30, 7 with in_last on the third psum, relu_en=0 -> out_data=77, out_cnt=3, out_forced=0, out_valid high 1 cycle after the third accept.
REQ-033 16 psums of -2^21 with no in_last -> out_data=-2^25, out_cnt=16, out_forced=1, and in_ready=0 on the cycle after the 16th accept.
REQ-034 Psums -5, 2 with in_last and relu_en=1 -> out_data=0; the same stimulus with relu_en=0 -> out_data=-3.
REQ-035 Group closed with out_ready=0 for 5 cycles -> outputs stable and in_ready=0 throughout; out_ready=1 -> IDLE with in_ready=1 on the next cycle.
REQ-036 reset_n pulsed low after 2 accepts of a group -> out_valid stays 0; next group of single psum 9 with in_last -> out_data=9, out_cnt=1.
REQ-037 Random psum streams with random valid gaps, group lengths and out_ready backpressure -> every result matches a reference sum and count; no group is lost or duplicated.
